mul_div_unit: RTL

- Iterative RV32M multiply/divide unit that executes the instructions the control unit flags with Mul_ext_o (opcode R-type, funct7[0]=1).
- Takes rs1/rs2 from the register file and funct3 from the instruction.
- Stalls PC/regfile write-enable while it computes, then presents the result on the writeback mux for exactly one cycle.
- Uses a shift-add multiplier and a restoring divider, with fixed latency for all ops.

---
 rtl/mul_div_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit.
// Shift-add multiplier and restoring divider share one accumulator pair.
// Every op takes a fixed XLEN iterations, then the result is shown for one cycle.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      f3;
    logic [XLEN-1:0] hi;      // product high half / partial remainder
    logic [XLEN-1:0] lo;      // multiplier bits / dividend-then-quotient bits
    logic [XLEN-1:0] mc;      // multiplicand magnitude / divisor magnitude
    logic            a_neg;
    logic            b_neg;
    logic            b_zero;

    // Operand preparation: signedness from funct3, then magnitudes
    logic            a_signed, b_signed, a_sgn, b_sgn;
    logic [XLEN-1:0] a_mag, b_mag;

    // Decode signedness and take absolute values of the incoming operands
    always_comb begin
        a_signed = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                   (funct3_i == 3'b100) || (funct3_i == 3'b110);
        b_signed = (funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                   (funct3_i == 3'b110);
        a_sgn    = a_signed & op_a_i[XLEN-1];
        b_sgn    = b_signed & op_b_i[XLEN-1];
        a_mag    = a_sgn ? (~op_a_i + 1'b1) : op_a_i;
        b_mag    = b_sgn ? (~op_b_i + 1'b1) : op_b_i;
    end

    // One iteration of either algorithm, plus sign-corrected final values
    logic [XLEN:0]     add, trial;
    logic [XLEN-1:0]   diff;
    logic              ge;
    logic [XLEN-1:0]   nxt_hi, nxt_lo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo, rem, final_res;

    // Datapath step: shift-add for multiply, restoring step for divide
    always_comb begin
        add   = {1'b0, hi} + (lo[0] ? {1'b0, mc} : {(XLEN+1){1'b0}});
        trial = {hi, lo[XLEN-1]};
        ge    = trial >= {1'b0, mc};
        diff  = trial[XLEN-1:0] - mc;
        if (f3[2]) begin
            nxt_hi = ge ? diff : trial[XLEN-1:0];
            nxt_lo = {lo[XLEN-2:0], ge};
        end else begin
            nxt_hi = add[XLEN:1];
            nxt_lo = {add[0], lo[XLEN-1:1]};
        end
        prod   = {nxt_hi, nxt_lo};
        prod_s = (a_neg ^ b_neg) ? (~prod + 1'b1) : prod;
        // A zero divisor gives all-ones regardless of dividend sign; the
        // remainder path already yields op_a since the magnitude passes through.
        quo    = b_zero ? {XLEN{1'b1}} :
                 ((a_neg ^ b_neg) ? (~nxt_lo + 1'b1) : nxt_lo);
        rem    = a_neg ? (~nxt_hi + 1'b1) : nxt_hi;
        case (f3)
            3'b000:                 final_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo;
            default:                final_res = rem;
        endcase
    end

    // Stall while a request is presented in IDLE and throughout CALC
    always_comb begin
        stall_o = 1'b0;
        if (state == CALC)      stall_o = 1'b1;
        else if (state == IDLE) stall_o = start_i;
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            cnt      <= '0;
            f3       <= '0;
            hi       <= '0;
            lo       <= '0;
            mc       <= '0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            b_zero   <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid_o <= 1'b0;
                    if (start_i && !kill_i) begin
                        f3     <= funct3_i;
                        a_neg  <= a_sgn;
                        b_neg  <= b_sgn;
                        b_zero <= (op_b_i == '0);
                        hi     <= '0;
                        lo     <= funct3_i[2] ? a_mag : b_mag;
                        mc     <= funct3_i[2] ? b_mag : a_mag;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (kill_i) begin
                        state <= IDLE;
                    end else begin
                        hi  <= nxt_hi;
                        lo  <= nxt_lo;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(XLEN-1)) begin
                            result_o <= final_res;
                            valid_o  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule
